// File: rtl/pixel_writer.sv
// pixel_writer: read-modify-write pixel engine for a 16-bit word memory.
// Packs 1/2/4/8/16 bpp pixels into words, supports masked writes with
// collision counting, a one-pixel copy buffer, and an ARGB register.
module pixel_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_cmd_rdy,
  input  logic [39:0] pixel_cmd,
  output logic        draw_busy,
  output logic [19:0] mem_addr,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [15:0] mem_wr_data,
  input  logic        mem_ack,
  input  logic        mem_rd_valid,
  input  logic [15:0] mem_rd_data,
  output logic [7:0]  collision_wri,
  output logic [7:0]  collision_paste,
  output logic [31:0] argb
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t      state, state_nx;
  logic [3:0]  op_cmd, op_wid, op_tb;
  logic [7:0]  op_col;
  logic [7:0]  copy_buf, wri_mask, paste_mask;

  // Low-aligned mask covering one pixel of width w+1 bits.
  function automatic logic [15:0] low_mask(input logic [3:0] w);
    logic [16:0] m;
    m = (17'd1 << ({1'b0, w} + 5'd1)) - 17'd1;
    return m[15:0];
  endfunction

  // Collision counters stop at full scale instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Incoming command fields.
  logic [3:0]  cmd_in, wid_in, tgt_in;
  logic [7:0]  col_in, src_in;
  logic [19:0] addr_in;
  logic        width_ok, is_draw_in, is_copy_in, skip16_in;
  logic        accept, start_rd, start_wr;

  assign cmd_in  = pixel_cmd[39:36];
  assign col_in  = pixel_cmd[35:28];
  assign wid_in  = pixel_cmd[27:24];
  assign tgt_in  = pixel_cmd[23:20];
  assign addr_in = pixel_cmd[19:0];

  assign width_ok   = (wid_in == 4'd0) || (wid_in == 4'd1) || (wid_in == 4'd3) ||
                      (wid_in == 4'd7) || (wid_in == 4'd15);
  assign is_draw_in = (cmd_in >= 4'd1) && (cmd_in <= 4'd4);
  assign is_copy_in = (cmd_in == 4'd6);
  assign src_in     = ((cmd_in == 4'd3) || (cmd_in == 4'd4)) ? copy_buf : col_in;
  // At 16 bpp there is no read, so the masked compare uses the full 8 bits.
  assign skip16_in  = ((cmd_in == 4'd2) && (col_in == wri_mask)) ||
                      ((cmd_in == 4'd4) && (copy_buf == paste_mask));

  assign accept   = (state == IDLE) && pixel_cmd_rdy;
  assign start_rd = accept && width_ok &&
                    (is_copy_in || (is_draw_in && (wid_in != 4'd15)));
  assign start_wr = accept && width_ok && is_draw_in && (wid_in == 4'd15) && !skip16_in;

  // Read-word processing for the operation in flight.
  logic [15:0] low, rd_pix, src_fld, mask_fld, merged;
  logic [7:0]  op_src, op_mask;
  logic        masked_op, skip_wr, rd_done;

  assign low       = low_mask(op_wid);
  assign op_src    = ((op_cmd == 4'd3) || (op_cmd == 4'd4)) ? copy_buf : op_col;
  assign op_mask   = (op_cmd == 4'd4) ? paste_mask : wri_mask;
  assign masked_op = (op_cmd == 4'd2) || (op_cmd == 4'd4);
  assign rd_pix    = (mem_rd_data >> op_tb) & low;
  assign src_fld   = {8'h00, op_src} & low;
  assign mask_fld  = {8'h00, op_mask} & low;
  assign skip_wr   = masked_op && (src_fld == mask_fld);
  assign merged    = (mem_rd_data & ~(low << op_tb)) | (src_fld << op_tb);
  assign rd_done   = (state == RD_WAIT) && mem_rd_valid;

  assign draw_busy  = (state != IDLE);
  assign mem_rd_req = (state == RD_REQ);
  assign mem_wr_req = (state == WR_REQ);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_rd) state_nx = RD_REQ;
               else if (start_wr) state_nx = WR_REQ;
      RD_REQ:  if (mem_ack) state_nx = RD_WAIT;
      RD_WAIT: if (mem_rd_valid)
                 state_nx = ((op_cmd == 4'd6) || skip_wr) ? IDLE : WR_REQ;
      WR_REQ:  if (mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operation latches, memory request payload and register-style commands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_cmd          <= 4'd0;
      op_col          <= 8'd0;
      op_wid          <= 4'd0;
      op_tb           <= 4'd0;
      mem_addr        <= 20'd0;
      mem_wr_data     <= 16'd0;
      copy_buf        <= 8'd0;
      wri_mask        <= 8'd0;
      paste_mask      <= 8'd0;
      collision_wri   <= 8'd0;
      collision_paste <= 8'd0;
      argb            <= 32'd0;
    end else begin
      if (start_rd || start_wr) begin
        op_cmd   <= cmd_in;
        op_col   <= col_in;
        op_wid   <= wid_in;
        // Align the target bit down to a pixel boundary.
        op_tb    <= tgt_in & ~wid_in;
        mem_addr <= {addr_in[19:1], 1'b0};
      end
      if (start_wr) mem_wr_data <= {8'h00, src_in};
      if (accept) begin
        case (cmd_in)
          4'd7:  argb <= pixel_cmd[31:0];
          4'd10: begin
            wri_mask      <= pixel_cmd[31:24];
            collision_wri <= 8'd0;
          end
          4'd11: begin
            paste_mask      <= pixel_cmd[31:24];
            collision_paste <= 8'd0;
          end
          default: ;
        endcase
      end
      if (rd_done) begin
        if (op_cmd == 4'd6) begin
          copy_buf <= rd_pix[7:0];
        end else if (!skip_wr) begin
          mem_wr_data <= merged;
          if ((op_cmd == 4'd2) && (rd_pix != 16'd0)) collision_wri <= sat_inc(collision_wri);
          if ((op_cmd == 4'd4) && (rd_pix != 16'd0)) collision_paste <= sat_inc(collision_paste);
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Testbench for pixel_writer: memory responder with configurable ack delay,
// expected writes queued as {addr,data} and popped when a write is acked.
module tb_pixel_writer;

  logic        clk;
  logic        reset;
  logic        pixel_cmd_rdy;
  logic [39:0] pixel_cmd;
  logic        draw_busy;
  logic [19:0] mem_addr;
  logic        mem_rd_req, mem_wr_req;
  logic [15:0] mem_wr_data;
  logic        mem_ack, mem_rd_valid;
  logic [15:0] mem_rd_data;
  logic [7:0]  collision_wri, collision_paste;
  logic [31:0] argb;

  pixel_writer dut (
    .clk(clk), .reset(reset), .pixel_cmd_rdy(pixel_cmd_rdy), .pixel_cmd(pixel_cmd),
    .draw_busy(draw_busy), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data), .mem_ack(mem_ack),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .collision_wri(collision_wri), .collision_paste(collision_paste), .argb(argb)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [35:0] exp_q[$];

  int          ack_delay = 0;
  logic        hold_rv   = 0;
  logic        inject_rv = 0;
  logic [15:0] rd_word   = 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [39:0] mk(input logic [3:0] c, input logic [7:0] col,
                                     input logic [3:0] w, input logic [3:0] t,
                                     input logic [19:0] a);
    return {c, col, w, t, a};
  endfunction

  // Bit-by-bit model: replace bpp bits starting at tb with the colour bits.
  function automatic logic [15:0] model_write(input logic [15:0] rd, input logic [7:0] col,
                                              input int bpp, input int tb);
    logic [15:0] r;
    r = rd;
    for (int i = 0; i < bpp; i++) r[tb + i] = (i < 8) ? col[i] : 1'b0;
    return r;
  endfunction

  task automatic got_write(input logic [19:0] a, input logic [15:0] d);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      check("unexpected_write", {a, d}, 36'h0);
    end else begin
      e = exp_q.pop_front();
      check("wr_addr", {16'h0, a}, {16'h0, e[35:16]});
      check("wr_data", {20'h0, d}, {20'h0, e[15:0]});
    end
  endtask

  // Memory responder, driven on the falling edge.
  initial begin
    int cnt;
    logic rv_pending;
    cnt = 0; rv_pending = 1'b0;
    mem_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 16'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rd_valid = 1'b0;
      if (inject_rv) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = rd_word;
      end else if (rv_pending) begin
        rv_pending = 1'b0;
        if (!hold_rv) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = rd_word;
        end
      end else if (!reset) begin
        cnt = 0;
      end else if (mem_rd_req || mem_wr_req) begin
        if (cnt >= ack_delay) begin
          mem_ack = 1'b1;
          cnt = 0;
          if (mem_wr_req) got_write(mem_addr, mem_wr_data);
          else rv_pending = 1'b1;
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic send(input logic [39:0] c);
    @(negedge clk);
    pixel_cmd = c;
    pixel_cmd_rdy = 1'b1;
    @(negedge clk);
    pixel_cmd_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (draw_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {35'h0, draw_busy}, 36'h0);
  endtask

  task automatic do_op(input string tag, input logic [39:0] c);
    send(c);
    wait_idle(tag);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},  {35'h0, draw_busy}, 36'h0);
    check({pfx, "_rdreq"}, {35'h0, mem_rd_req}, 36'h0);
    check({pfx, "_wrreq"}, {35'h0, mem_wr_req}, 36'h0);
    check({pfx, "_addr"},  {16'h0, mem_addr}, 36'h0);
    check({pfx, "_wdata"}, {20'h0, mem_wr_data}, 36'h0);
    check({pfx, "_cwri"},  {28'h0, collision_wri}, 36'h0);
    check({pfx, "_cpaste"},{28'h0, collision_paste}, 36'h0);
    check({pfx, "_argb"},  {4'h0, argb}, 36'h0);
  endtask

  initial begin
    int n;
    int wl[5];
    wl = '{0, 1, 3, 7, 15};
    reset = 1'b0; pixel_cmd_rdy = 1'b0; pixel_cmd = 40'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;

    // 16 bpp write, ack two cycles late; busy lasts through the ack cycle.
    ack_delay = 2;
    exp_q.push_back({20'h00124, 16'h005A});
    send(mk(4'd1, 8'h5A, 4'd15, 4'd0, 20'h00124));
    n = 0;
    while (draw_busy && n < 100) begin n++; @(negedge clk); end
    check("busy_cycles_16bpp", 36'(n), 36'd3);
    ack_delay = 0;

    // 4 bpp read-modify-write, target bit 5 aligns to 4.
    rd_word = 16'hFFFF;
    exp_q.push_back({20'h00200, 16'hFFCF});
    do_op("idle_4bpp", mk(4'd1, 8'h0C, 4'd3, 4'd5, 20'h00200));

    // ARGB load completes in the accept cycle, never busy.
    send({4'd7, 4'h0, 32'hDEADBEEF});
    check("argb", {4'h0, argb}, {4'h0, 32'hDEADBEEF});
    check("argb_nobusy", {35'h0, draw_busy}, 36'h0);

    // Unsupported width is dropped.
    send(mk(4'd1, 8'hFF, 4'd2, 4'd0, 20'h00300));
    check("badwidth_nobusy", {35'h0, draw_busy}, 36'h0);

    // Masked write: matching colour reads but does not write.
    send({4'd10, 4'h0, 8'h03, 24'h0});
    check("cwri_clear", {28'h0, collision_wri}, 36'h0);
    rd_word = 16'h0000;
    do_op("idle_mask_skip", mk(4'd2, 8'h03, 4'd1, 4'd0, 20'h00010));
    rd_word = 16'h0008;
    exp_q.push_back({20'h00010, 16'h0004});
    do_op("idle_mask_wr", mk(4'd2, 8'h01, 4'd1, 4'd2, 20'h00010));
    check("cwri_one", {28'h0, collision_wri}, 36'd1);

    // 16 bpp masked write: match stays idle, mismatch writes without a read.
    send(mk(4'd2, 8'h03, 4'd15, 4'd0, 20'h00020));
    check("mask16_nobusy", {35'h0, draw_busy}, 36'h0);
    exp_q.push_back({20'h00020, 16'h005A});
    do_op("idle_mask16_wr", mk(4'd2, 8'h5A, 4'd15, 4'd0, 20'h00020));
    check("cwri_still_one", {28'h0, collision_wri}, 36'd1);

    // Copy a pixel, then paste it elsewhere.
    rd_word = 16'hAB12;
    do_op("idle_copy", mk(4'd6, 8'h00, 4'd7, 4'd8, 20'h00040));
    rd_word = 16'h0000;
    exp_q.push_back({20'h00042, 16'h00AB});
    do_op("idle_paste", mk(4'd3, 8'h00, 4'd7, 4'd0, 20'h00042));

    // Masked paste: match skips, mismatch over nonzero pixel counts.
    send({4'd11, 4'h0, 8'hAB, 24'h0});
    rd_word = 16'h00FF;
    do_op("idle_pastem_skip", mk(4'd4, 8'h00, 4'd7, 4'd0, 20'h00050));
    check("cpaste_zero", {28'h0, collision_paste}, 36'h0);
    send({4'd11, 4'h0, 8'h00, 24'h0});
    rd_word = 16'h1234;
    exp_q.push_back({20'h00050, 16'hAB34});
    do_op("idle_pastem_wr", mk(4'd4, 8'h00, 4'd7, 4'd8, 20'h00050));
    check("cpaste_one", {28'h0, collision_paste}, 36'd1);

    // 1 bpp top bit, address bit0 dropped.
    rd_word = 16'h0000;
    exp_q.push_back({20'h00332, 16'h8000});
    do_op("idle_1bpp", mk(4'd1, 8'hFF, 4'd0, 4'd15, 20'h00333));

    // Random plain writes against the bit-level model.
    for (int k = 0; k < 10; k++) begin
      int w, bpp, tbe;
      logic [7:0] col;
      logic [3:0] tgt;
      logic [19:0] a;
      w   = wl[$urandom_range(0, 4)];
      bpp = w + 1;
      tgt = 4'($urandom_range(0, 15));
      tbe = (int'(tgt) / bpp) * bpp;
      col = 8'($urandom);
      a   = 20'($urandom);
      rd_word = (w == 15) ? 16'h0000 : 16'($urandom);
      exp_q.push_back({a[19:1], 1'b0, model_write(rd_word, col, bpp, tbe)});
      do_op("idle_rand", mk(4'd1, col, 4'(w), tgt, a));
    end

    // Reset while waiting for read data; late read data afterwards is ignored.
    hold_rv = 1'b1;
    rd_word = 16'h5555;
    send(mk(4'd1, 8'h0F, 4'd3, 4'd0, 20'h00600));
    n = 0;
    while (!(draw_busy && !mem_rd_req) && n < 50) begin n++; @(negedge clk); end
    check("in_rd_wait", {35'h0, draw_busy}, 36'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b1;
    hold_rv = 1'b0;
    @(posedge clk); inject_rv = 1'b1;
    @(posedge clk); inject_rv = 1'b0;
    repeat (3) @(negedge clk);
    check("late_rv_busy", {35'h0, draw_busy}, 36'h0);
    check("late_rv_wrreq", {35'h0, mem_wr_req}, 36'h0);

    // Collision counter saturation, then clear.
    send({4'd10, 4'h0, 8'h00, 24'h0});
    rd_word = 16'h0011;
    for (int k = 0; k < 300; k++) begin
      exp_q.push_back({20'h00400, 16'h0001});
      send(mk(4'd2, 8'h01, 4'd7, 4'd0, 20'h00400));
      n = 0;
      while (draw_busy && n < 50) begin n++; @(negedge clk); end
    end
    check("cwri_sat", {28'h0, collision_wri}, 36'd255);
    send({4'd10, 4'h0, 8'h00, 24'h0});
    check("cwri_cleared", {28'h0, collision_wri}, 36'h0);

    repeat (3) @(negedge clk);
    check("sb_empty", 36'(exp_q.size()), 36'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous reset, active-low (asserted at 0).
REQ-003 SHALL have ports: pixel_cmd_rdy  in  1  pixel_cmd valid this cycle.
REQ-004 SHALL have ports: pixel_cmd  in  40  [39:36] CMD, [35:28] colour, [27:24] width (bpp-1), [23:20] target bit, [19:0] byte address, bit0 ignored.
REQ-005 SHALL have ports: draw_busy  out  1  high while a memory operation is in progress; upstream holds its command.
REQ-006 SHALL have ports: mem_addr  out  20  byte address, bit0 always 0; mem_rd_req  out  1; mem_wr_req  out  1; mem_wr_data  out  16; mem_ack  in  1  request accepted; mem_rd_valid  in  1  mem_rd_data valid; mem_rd_data  in  16.
REQ-007 SHALL have ports: collision_wri  out  8; collision_paste  out  8; argb  out  32  last SETARGB value.

Function
REQ-008 SHALL implement states IDLE, RD_REQ, RD_WAIT, WR_REQ.
REQ-009 SHALL set draw_busy = (state != IDLE), combinationally.
REQ-010 SHALL accept a command only in IDLE with pixel_cmd_rdy=1; pixel_cmd is ignored otherwise.
REQ-011 SHALL support widths 0,1,3,7,15 (1/2/4/8/16 bpp); any other width SHALL drop the command, stay IDLE and change no state.
REQ-012 SHALL place a pixel at bits [tb+bpp-1:tb], where tb = target bit with its low log2(bpp) bits cleared.
REQ-013 SHALL zero-extend 8-bit colour to bpp and write it; for bpp<8 the upper colour bits SHALL be discarded.
REQ-014 CMD 1 (PXWRI) and CMD 2 (PXWRI_M) SHALL use the colour field; CMD 3 (PXPASTE) and CMD 4 (PXPASTE_M) SHALL use copy_buf.
REQ-015 CMD 1/2/3/4 at 16 bpp SHALL go IDLE->WR_REQ with mem_wr_data = {8'h00, colour}.
REQ-016 CMD 1/2/3/4 at bpp<16 SHALL go IDLE->RD_REQ->RD_WAIT->WR_REQ; the write SHALL replace only the pixel field in the read word.
REQ-017 CMD 6 (PXCOPY) SHALL go IDLE->RD_REQ->RD_WAIT->IDLE and load the extracted pixel into copy_buf[7:0]; at 16 bpp it SHALL load rd_data[7:0].
REQ-018 Requests SHALL hold mem_rd_req or mem_wr_req plus mem_addr and mem_wr_data stable until the cycle mem_ack=1.
REQ-019 Transitions SHALL be: RD_REQ->RD_WAIT on mem_ack; RD_WAIT->next state on mem_rd_valid; WR_REQ->IDLE on mem_ack.
REQ-020 Write latency at 16 bpp SHALL be: accept cycle, then the WR_REQ cycle(s); draw_busy falls the cycle after mem_ack.
REQ-021 mem_rd_valid outside RD_WAIT SHALL be ignored; mem_ack in IDLE SHALL be ignored.
REQ-022 CMD 2: if colour[bpp-1:0] == wri_mask[bpp-1:0], no write SHALL occur and the state SHALL return to IDLE after RD_WAIT (16 bpp: compare 8 bits, no read, return to IDLE directly).
REQ-023 CMD 2: when a write occurs over a nonzero read pixel, collision_wri SHALL increment, saturating at 255.
REQ-024 CMD 4: same as REQ-022 and REQ-023 using copy_buf, paste_mask and collision_paste.
REQ-025 CMD 7 SHALL load argb <= pixel_cmd[31:0]; this SHALL complete in the accept cycle, with no busy.
REQ-026 CMD 10 SHALL set wri_mask <= pixel_cmd[31:24] and clear collision_wri, in the accept cycle.
REQ-027 CMD 11 SHALL do the same as CMD 10 using paste_mask and collision_paste.
REQ-028 CMD 0, 5, 8, 9 and 12-15 SHALL be NOPs.

Reset
REQ-029 While reset=0: state=IDLE; draw_busy=0; mem_rd_req=0; mem_wr_req=0; mem_addr=0; mem_wr_data=0; copy_buf=0; wri_mask=0; paste_mask=0; collision counters=0; argb=0.
REQ-030 Reset mid-operation SHALL abort immediately and drop any outstanding request; a late mem_ack or mem_rd_valid after release SHALL be ignored (REQ-021).

Verification
REQ-031 CMD1, 16 bpp, addr 0x00124, colour 0x5A, mem_ack 2 cycles late -> one write, addr 0x00124, data 0x005A; draw_busy high exactly until the cycle after mem_ack.
REQ-032 CMD1, 4 bpp, tb=5, colour 0x0C, read word 0xFFFF -> tb=4; write 0xFFCF.
REQ-033 CMD10 mask 0x03, then CMD2 2 bpp colour 0x03 -> read, no write; then CMD2 colour 0x01 over pixel 0x2 -> write occurs, collision_wri=1.
REQ-034 CMD6 8 bpp tb=8, read 0xAB12; then CMD3 to tb=0 over 0x0000 -> write 0x00AB.
REQ-035 Assert reset during RD_WAIT, then apply mem_rd_valid -> IDLE, no write, all outputs at reset values.
REQ-036 Issue 300 CMD2 overwriting nonzero pixels, then CMD10 -> collision_wri holds 255 until CMD10 clears it to 0.
